// File: rtl/uart_mmio_bridge_pkg.sv
// Shared I/O map for the UART MMIO bridge and the CPU memory-stage mux.
// Holds the register addresses, the I/O region mask and the address decoder.
package uart_mmio_bridge_pkg;

  localparam logic [31:0] IO_REGION_MASK = 32'h8000_0000;

  localparam logic [31:0] ADDR_TX_CTRL   = 32'h8000_0000;
  localparam logic [31:0] ADDR_RX_CTRL   = 32'h8000_0004;
  localparam logic [31:0] ADDR_TX_DATA   = 32'h8000_0008;
  localparam logic [31:0] ADDR_RX_DATA   = 32'h8000_000C;
  localparam logic [31:0] ADDR_CYCLE_CNT = 32'h8000_0010;
  localparam logic [31:0] ADDR_CNT_CLR   = 32'h8000_0018;

  typedef enum logic [2:0] {
    REG_NONE,
    REG_TX_CTRL,
    REG_RX_CTRL,
    REG_TX_DATA,
    REG_RX_DATA,
    REG_CYCLE_CNT,
    REG_CNT_CLR
  } io_reg_e;

  // Word-aligned match: the byte offset within the word is ignored.
  function automatic io_reg_e decode_addr(input logic [31:0] addr);
    case ({addr[31:2], 2'b00})
      ADDR_TX_CTRL:   decode_addr = REG_TX_CTRL;
      ADDR_RX_CTRL:   decode_addr = REG_RX_CTRL;
      ADDR_TX_DATA:   decode_addr = REG_TX_DATA;
      ADDR_RX_DATA:   decode_addr = REG_RX_DATA;
      ADDR_CYCLE_CNT: decode_addr = REG_CYCLE_CNT;
      ADDR_CNT_CLR:   decode_addr = REG_CNT_CLR;
      default:        decode_addr = REG_NONE;
    endcase
  endfunction

endpackage

// File: rtl/uart_mmio_bridge_sync_fifo.sv
// Single-clock FIFO with the head entry always visible on dout.
// Pushes while full and pops while empty are ignored.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign dout    = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // NOTE: storage has no reset; pointers and count alone define validity,
  // which keeps the array a plain RAM without a reset fan-out.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every register samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_mmio_bridge.sv
// MMIO bridge between the CPU memory stage and the UART byte interface:
// RX FIFO, single-entry TX holding register, cycle counter and registered read mux.
module uart_mmio_bridge
  import uart_mmio_bridge_pkg::*;
#(
  parameter int RX_DEPTH = 8,
  parameter int RX_AW    = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        we,
  input  logic        re,
  output logic        sel,
  output logic [31:0] rdata,
  output logic [7:0]  uart_din,
  output logic        uart_din_valid,
  input  logic        uart_din_ready,
  input  logic [7:0]  uart_dout,
  input  logic        uart_dout_valid,
  output logic        uart_dout_ready
);

  io_reg_e     reg_sel;
  logic        acc;
  logic        rx_push, rx_pop, rx_full, rx_empty;
  logic [7:0]  rx_head;
  logic [RX_AW:0] rx_count;
  logic        tx_store;

  logic [31:0] rdata_q, rdata_d;
  logic [31:0] cnt_q, cnt_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        tx_full_q, tx_full_d;

  assign reg_sel = decode_addr(addr);
  assign sel     = (reg_sel != REG_NONE);
  assign acc     = !stall && !rst;

  // Ready is masked by reset so a byte offered during reset stays with the UART.
  assign uart_dout_ready = !rst && !rx_full;
  assign rx_push         = uart_dout_valid && uart_dout_ready;
  assign rx_pop          = acc && re && (reg_sel == REG_RX_DATA) && !rx_empty;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (RX_DEPTH),
    .AW    (RX_AW)
  ) u_rx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rx_push),
    .din   (uart_dout),
    .pop   (rx_pop),
    .dout  (rx_head),
    .full  (rx_full),
    .empty (rx_empty),
    .count (rx_count)
  );

  // Gated on the pre-drain flag: a store in the drain cycle is refused.
  assign tx_store = acc && we && (reg_sel == REG_TX_DATA) && !tx_full_q;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    rdata_d   = rdata_q;
    tx_data_d = tx_data_q;
    tx_full_d = tx_full_q;
    cnt_d     = cnt_q + 32'd1;

    if (acc && re) begin
      case (reg_sel)
        REG_TX_CTRL:   rdata_d = {31'b0, !tx_full_q};
        REG_RX_CTRL:   rdata_d = {31'b0, (rx_count != '0)};
        REG_RX_DATA:   rdata_d = {24'b0, rx_empty ? 8'h00 : rx_head};
        REG_CYCLE_CNT: rdata_d = cnt_q;
        default:       rdata_d = 32'b0;
      endcase
    end

    if (tx_full_q && uart_din_ready) tx_full_d = 1'b0;
    if (tx_store) begin
      tx_full_d = 1'b1;
      tx_data_d = wdata[7:0];
    end

    if (acc && we && (reg_sel == REG_CNT_CLR)) cnt_d = 32'd0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q   <= '0;
      tx_data_q <= '0;
      tx_full_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      rdata_q   <= rdata_d;
      tx_data_q <= tx_data_d;
      tx_full_q <= tx_full_d;
      cnt_q     <= cnt_d;
    end
  end

  assign rdata          = rdata_q;
  assign uart_din       = tx_data_q;
  assign uart_din_valid = tx_full_q;

  logic unused_bits;
  assign unused_bits = &{1'b0, wdata[31:8], addr[1:0]};

endmodule

// File: tb/tb_uart_mmio_bridge.sv
// Directed self-checking bench for uart_mmio_bridge.
module tb_uart_mmio_bridge;

  localparam logic [31:0] A_TX_CTRL = 32'h8000_0000;
  localparam logic [31:0] A_RX_CTRL = 32'h8000_0004;
  localparam logic [31:0] A_TX_DATA = 32'h8000_0008;
  localparam logic [31:0] A_RX_DATA = 32'h8000_000C;
  localparam logic [31:0] A_CNT     = 32'h8000_0010;
  localparam logic [31:0] A_CLR     = 32'h8000_0018;

  logic        clk, rst, stall, we, re, sel;
  logic [31:0] addr, wdata, rdata;
  logic [7:0]  uart_din, uart_dout;
  logic        uart_din_valid, uart_din_ready, uart_dout_valid, uart_dout_ready;

  int checks = 0;
  int errors = 0;

  uart_mmio_bridge #(.RX_DEPTH(8), .RX_AW(3)) dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .addr            (addr),
    .wdata           (wdata),
    .we              (we),
    .re              (re),
    .sel             (sel),
    .rdata           (rdata),
    .uart_din        (uart_din),
    .uart_din_valid  (uart_din_valid),
    .uart_din_ready  (uart_din_ready),
    .uart_dout       (uart_dout),
    .uart_dout_valid (uart_dout_valid),
    .uart_dout_ready (uart_dout_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic bus_load(input logic [31:0] a, input logic st, output logic [31:0] d);
    @(negedge clk);
    addr = a; re = 1'b1; stall = st;
    @(posedge clk); #1;
    d = rdata; re = 1'b0; stall = 1'b0;
  endtask

  task automatic bus_store(input logic [31:0] a, input logic [31:0] wd, input logic st);
    @(negedge clk);
    addr = a; wdata = wd; we = 1'b1; stall = st;
    @(posedge clk); #1;
    we = 1'b0; stall = 1'b0;
  endtask

  task automatic uart_send(input logic [7:0] b);
    @(negedge clk);
    uart_dout = b; uart_dout_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (uart_dout_ready) break;
      @(negedge clk);
    end
    checks++;
    if (!uart_dout_ready) begin
      errors++;
      $display("FAIL uart_send_timeout: ready=%b required=1 byte=%h", uart_dout_ready, b);
    end
    @(posedge clk); #1;
    uart_dout_valid = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (uart_dout_ready !== 1'b0) begin
      errors++; $display("FAIL rst_dout_ready: got %b required 0", uart_dout_ready);
    end
    @(negedge clk); rst = 1'b0; #1;
    checks++;
    if (rdata !== 32'h0) begin
      errors++; $display("FAIL rst_rdata: got %h required 00000000", rdata);
    end
    checks++;
    if (uart_din_valid !== 1'b0 || uart_din !== 8'h00) begin
      errors++; $display("FAIL rst_tx: got valid=%b din=%h required 0/00", uart_din_valid, uart_din);
    end
    checks++;
    if (uart_dout_ready !== 1'b1) begin
      errors++; $display("FAIL rst_release_ready: got %b required 1", uart_dout_ready);
    end
    bus_load(A_RX_CTRL, 1'b0, d);
    checks++;
    if (d !== 32'h0) begin
      errors++; $display("FAIL rst_rx_ctrl: got %h required 00000000", d);
    end
  endtask

  task automatic test_decode();
    logic [31:0] d;
    logic [31:0] probe [6];
    logic        exp_sel [6];
    probe = '{32'h8000_0000, 32'h8000_0011, 32'h8000_001B, 32'h8000_0014, 32'h8000_001C, 32'h0000_0004};
    exp_sel = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); addr = probe[i]; #1;
      checks++;
      if (sel !== exp_sel[i]) begin
        errors++; $display("FAIL decode_sel addr=%h: got %b required %b", probe[i], sel, exp_sel[i]);
      end
    end
    bus_load(A_TX_CTRL, 1'b0, d);
    checks++;
    if (d !== 32'h1) begin
      errors++; $display("FAIL decode_tx_ctrl_idle: got %h required 00000001", d);
    end
    bus_load(32'h8000_0014, 1'b0, d);
    checks++;
    if (d !== 32'h0) begin
      errors++; $display("FAIL decode_unmapped_read: got %h required 00000000", d);
    end
  endtask

  task automatic test_rx_basic();
    logic [31:0] d;
    uart_send(8'h7A);
    uart_send(8'h41);
    bus_load(A_RX_CTRL, 1'b0, d);
    checks++;
    if (d !== 32'h1) begin
      errors++; $display("FAIL rx_ctrl_nonempty: got %h required 00000001", d);
    end
    bus_load(A_RX_DATA, 1'b0, d);
    checks++;
    if (d !== 32'h7A) begin
      errors++; $display("FAIL rx_data_first: got %h required 0000007a", d);
    end
    bus_load(A_RX_DATA, 1'b0, d);
    checks++;
    if (d !== 32'h41) begin
      errors++; $display("FAIL rx_data_second: got %h required 00000041", d);
    end
    bus_load(A_RX_CTRL, 1'b0, d);
    checks++;
    if (d !== 32'h0) begin
      errors++; $display("FAIL rx_ctrl_empty: got %h required 00000000", d);
    end
  endtask

  task automatic test_rx_full();
    logic [31:0] d;
    for (int i = 0; i < 8; i++) uart_send(8'h10 + 8'(i));
    @(negedge clk);
    uart_dout = 8'h18; uart_dout_valid = 1'b1; #1;
    checks++;
    if (uart_dout_ready !== 1'b0) begin
      errors++; $display("FAIL rx_full_ready: got %b required 0", uart_dout_ready);
    end
    bus_load(A_RX_DATA, 1'b0, d);
    checks++;
    if (d !== 32'h10) begin
      errors++; $display("FAIL rx_full_pop0: got %h required 00000010", d);
    end
    checks++;
    if (uart_dout_ready !== 1'b1) begin
      errors++; $display("FAIL rx_after_pop_ready: got %b required 1", uart_dout_ready);
    end
    @(posedge clk); #1;
    uart_dout_valid = 1'b0;
    checks++;
    if (uart_dout_ready !== 1'b0) begin
      errors++; $display("FAIL rx_refill_ready: got %b required 0", uart_dout_ready);
    end
    for (int i = 1; i < 9; i++) begin
      bus_load(A_RX_DATA, 1'b0, d);
      checks++;
      if (d !== 32'h10 + 32'(i)) begin
        errors++; $display("FAIL rx_wrap_drain[%0d]: got %h required %h", i, d, 32'h10 + 32'(i));
      end
    end
    bus_load(A_RX_CTRL, 1'b0, d);
    checks++;
    if (d !== 32'h0) begin
      errors++; $display("FAIL rx_wrap_empty: got %h required 00000000", d);
    end
  endtask

  task automatic test_tx();
    logic [31:0] d;
    int sends;
    uart_din_ready = 1'b0;
    bus_store(A_TX_DATA, 32'hFFFF_FF55, 1'b0);
    checks++;
    if (uart_din_valid !== 1'b1 || uart_din !== 8'h55) begin
      errors++; $display("FAIL tx_load: got valid=%b din=%h required 1/55", uart_din_valid, uart_din);
    end
    bus_load(A_TX_CTRL, 1'b0, d);
    checks++;
    if (d !== 32'h0) begin
      errors++; $display("FAIL tx_ctrl_full: got %h required 00000000", d);
    end
    bus_store(A_TX_DATA, 32'h0000_00AA, 1'b0);
    checks++;
    if (uart_din !== 8'h55) begin
      errors++; $display("FAIL tx_drop_when_full: got din=%h required 55", uart_din);
    end
    sends = 0;
    @(negedge clk); uart_din_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (uart_din_valid && uart_din_ready && uart_din == 8'h55) sends++;
      @(negedge clk);
    end
    uart_din_ready = 1'b0;
    checks++;
    if (sends != 1) begin
      errors++; $display("FAIL tx_send_once: got %0d sends required 1", sends);
    end
    bus_load(A_TX_CTRL, 1'b0, d);
    checks++;
    if (d !== 32'h1) begin
      errors++; $display("FAIL tx_ctrl_free: got %h required 00000001", d);
    end
    // Drain and store in the same cycle: the store must be refused.
    bus_store(A_TX_DATA, 32'h11, 1'b0);
    @(negedge clk);
    addr = A_TX_DATA; wdata = 32'h22; we = 1'b1; uart_din_ready = 1'b1;
    @(posedge clk); #1;
    we = 1'b0; uart_din_ready = 1'b0;
    checks++;
    if (uart_din_valid !== 1'b0 || uart_din !== 8'h11) begin
      errors++; $display("FAIL tx_drain_and_store: got valid=%b din=%h required 0/11", uart_din_valid, uart_din);
    end
  endtask

  task automatic test_stall();
    logic [31:0] d;
    logic [31:0] prev;
    uart_send(8'h3C);
    prev = rdata;
    bus_load(A_RX_DATA, 1'b1, d);
    checks++;
    if (d !== prev) begin
      errors++; $display("FAIL stall_rdata_hold: got %h required %h", d, prev);
    end
    bus_load(A_RX_CTRL, 1'b0, d);
    checks++;
    if (d !== 32'h1) begin
      errors++; $display("FAIL stall_no_pop: got %h required 00000001", d);
    end
    bus_load(A_RX_DATA, 1'b0, d);
    checks++;
    if (d !== 32'h3C) begin
      errors++; $display("FAIL stall_then_pop: got %h required 0000003c", d);
    end
    bus_load(A_RX_DATA, 1'b0, d);
    checks++;
    if (d !== 32'h0) begin
      errors++; $display("FAIL pop_empty_zero: got %h required 00000000", d);
    end
    bus_store(A_TX_DATA, 32'h99, 1'b1);
    checks++;
    if (uart_din_valid !== 1'b0) begin
      errors++; $display("FAIL stall_store_dropped: got valid=%b required 0", uart_din_valid);
    end
  endtask

  task automatic test_counter();
    logic [31:0] c1, c2, d;
    @(negedge clk);
    addr = A_CNT; re = 1'b1;
    @(posedge clk); #1; c1 = rdata;
    repeat (10) @(posedge clk);
    #1; c2 = rdata;
    re = 1'b0;
    checks++;
    if (c2 - c1 !== 32'd10) begin
      errors++; $display("FAIL cnt_delta: got %0d required 10", c2 - c1);
    end
    bus_store(A_CLR, 32'h0, 1'b0);
    bus_load(A_CNT, 1'b0, d);
    checks++;
    if (d !== 32'h0) begin
      errors++; $display("FAIL cnt_clear: got %h required 00000000", d);
    end
    @(negedge clk);
    addr = A_CNT; re = 1'b1;
    force dut.cnt_q = 32'hFFFF_FFFF;
    #1 release dut.cnt_q;
    @(posedge clk); #1;
    checks++;
    if (rdata !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL cnt_max: got %h required ffffffff", rdata);
    end
    @(posedge clk); #1;
    re = 1'b0;
    checks++;
    if (rdata !== 32'h0) begin
      errors++; $display("FAIL cnt_wrap: got %h required 00000000", rdata);
    end
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; we = 1'b0; re = 1'b0;
    addr = 32'h0; wdata = 32'h0;
    uart_din_ready = 1'b0; uart_dout = 8'h0; uart_dout_valid = 1'b0;
    test_reset();
    test_decode();
    test_rx_basic();
    test_rx_full();
    test_tx();
    test_stall();
    test_counter();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
